// File: rtl/avalon_slave_fifo_pkg.sv
// Shared definitions for the Avalon-MM burst slave: burst count width,
// FSM state encodings and the burstcount normalisation helper.
package avalon_slave_fifo_pkg;

    localparam int unsigned BURST_W = 9;
    localparam logic [BURST_W-1:0] BEAT_ONE = BURST_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITE_BURST = 2'd1,
        ST_READ_DATA   = 2'd2
    } state_t;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [BURST_W-1:0] burst_beats(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? BEAT_ONE : bc;
    endfunction

endpackage

// File: rtl/avs_data_fifo.sv
// Synchronous FIFO with asynchronous-read storage and registered status flags.
// Pushes into a full FIFO are dropped; pops from an empty FIFO are ignored.
module avs_data_fifo #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enq,
    input  logic [DATA_W-1:0] i_enq_data,
    input  logic              i_deq,
    output logic [DATA_W-1:0] o_head,
    output logic              o_empty,
    output logic              o_almost_full
);

    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AF      = (ADDR_W+1)'(DEPTH - 3);
    localparam logic [ADDR_W:0] C_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_next;
    logic              r_empty;
    logic              r_full;
    logic              r_af;
    logic              w_do_enq;
    logic              w_do_deq;

    assign w_do_enq      = i_enq && !r_full;
    assign w_do_deq      = i_deq && !r_empty;
    assign o_head        = r_mem[r_rd_ptr];
    assign o_empty       = r_empty;
    assign o_almost_full = r_af;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_do_enq && !w_do_deq) begin
            w_count_next = r_count + C_CNT_ONE;
        end else if (!w_do_enq && w_do_deq) begin
            w_count_next = r_count - C_CNT_ONE;
        end
    end

    // Pointers, occupancy and flags; flags are registered from the next occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
        end else begin
            if (w_do_enq) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_do_deq) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == C_DEPTH);
            r_af    <= (w_count_next >= C_AF);
        end
    end

    // Data storage, written on accepted pushes only.
    always_ff @(posedge i_clk) begin
        if (w_do_enq) begin
            r_mem[r_wr_ptr] <= i_enq_data;
        end
    end

endmodule

// File: rtl/avalon_slave_fifo.sv
// Avalon-MM burst slave: accepts one read or write burst at a time, buffers write
// beats for user logic and returns user-supplied read words as readdatavalid beats.
module avalon_slave_fifo
    import avalon_slave_fifo_pkg::*;
#(
    parameter int unsigned FIFO_ADDR_WIDTH  = 4,
    parameter int unsigned C_AVS_ADDR_WIDTH = 32,
    parameter int unsigned C_AVS_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_AVS_ADDR_WIDTH-1:0]   avs_address,
    input  logic                          avs_read,
    input  logic                          avs_write,
    input  logic [C_AVS_DATA_WIDTH-1:0]   avs_writedata,
    input  logic [C_AVS_DATA_WIDTH/8-1:0] avs_byteenable,
    input  logic [BURST_W-1:0]            avs_burstcount,
    output logic                          avs_waitrequest,
    output logic [C_AVS_DATA_WIDTH-1:0]   avs_readdata,
    output logic                          avs_readdatavalid,
    output logic                          user_cmd_valid,
    output logic                          user_cmd_read,
    output logic                          user_cmd_write,
    output logic [C_AVS_ADDR_WIDTH-1:0]   user_cmd_addr,
    output logic [BURST_W-1:0]            user_cmd_word_size,
    input  logic                          user_write_deq,
    output logic [C_AVS_DATA_WIDTH-1:0]   user_write_data,
    output logic                          user_write_empty,
    input  logic                          user_read_enq,
    input  logic [C_AVS_DATA_WIDTH-1:0]   user_read_data,
    output logic                          user_read_almost_full,
    output logic                          user_done
);

    localparam int unsigned BYTE_LSB = $clog2(C_AVS_DATA_WIDTH / 8);

    state_t                        r_state;
    logic [BURST_W-1:0]            r_cnt;
    logic [BURST_W-1:0]            r_burst;
    logic [C_AVS_ADDR_WIDTH-1:0]   r_cmd_addr;
    logic                          r_cmd_valid;
    logic                          r_cmd_read;
    logic                          r_cmd_write;
    logic                          r_done;
    logic                          r_rdv;
    logic [C_AVS_DATA_WIDTH-1:0]   r_rdata;

    logic [C_AVS_ADDR_WIDTH-1:0]   w_addr_aligned;
    logic [BURST_W-1:0]            w_burst_in;
    logic                          w_wait;
    logic                          w_wf_enq;
    logic                          w_wf_af;
    logic                          w_rf_deq;
    logic                          w_rf_empty;
    logic [C_AVS_DATA_WIDTH-1:0]   w_rf_head;
    logic                          w_last;
    logic                          w_unused;

    // Byte enables carry no information: only full words are transferred.
    assign w_unused = ^avs_byteenable;

    assign w_burst_in = burst_beats(avs_burstcount);
    assign w_wait     = (r_state == ST_READ_DATA) || w_wf_af;
    assign w_wf_enq   = avs_write && !w_wait;
    assign w_rf_deq   = (r_state == ST_READ_DATA) && !w_rf_empty;
    assign w_last     = (r_cnt == r_burst - BEAT_ONE);

    assign avs_waitrequest    = w_wait;
    assign avs_readdata       = r_rdata;
    assign avs_readdatavalid  = r_rdv;
    assign user_cmd_valid     = r_cmd_valid;
    assign user_cmd_read      = r_cmd_read;
    assign user_cmd_write     = r_cmd_write;
    assign user_cmd_addr      = r_cmd_addr;
    assign user_cmd_word_size = r_burst;
    assign user_done          = r_done;

    // Word-align the burst start address.
    always_comb begin
        w_addr_aligned = avs_address;
        for (int unsigned i = 0; i < BYTE_LSB; i++) begin
            w_addr_aligned[i] = 1'b0;
        end
    end

    // Burst FSM: command capture, beat counting and done/readdata pulses.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_burst     <= '0;
            r_cmd_addr  <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_read  <= 1'b0;
            r_cmd_write <= 1'b0;
            r_done      <= 1'b0;
            r_rdv       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_read  <= 1'b0;
            r_cmd_write <= 1'b0;
            r_done      <= 1'b0;
            r_rdv       <= w_rf_deq;
            if (w_rf_deq) begin
                r_rdata <= w_rf_head;
            end
            case (r_state)
                ST_IDLE: begin
                    // A write wins over a simultaneous read.
                    if (w_wf_enq) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_write <= 1'b1;
                        r_cmd_addr  <= w_addr_aligned;
                        r_burst     <= w_burst_in;
                        if (w_burst_in == BEAT_ONE) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt   <= BEAT_ONE;
                            r_state <= ST_WRITE_BURST;
                        end
                    end else if (avs_read && !w_wait) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_read  <= 1'b1;
                        r_cmd_addr  <= w_addr_aligned;
                        r_burst     <= w_burst_in;
                        r_cnt       <= '0;
                        r_state     <= ST_READ_DATA;
                    end
                end
                ST_WRITE_BURST: begin
                    if (w_wf_enq) begin
                        r_cnt <= r_cnt + BEAT_ONE;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_READ_DATA: begin
                    if (w_rf_deq) begin
                        r_cnt <= r_cnt + BEAT_ONE;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    avs_data_fifo #(
        .ADDR_W (FIFO_ADDR_WIDTH),
        .DATA_W (C_AVS_DATA_WIDTH)
    ) u_write_fifo (
        .i_clk         (ACLK),
        .i_rst         (ARESET),
        .i_enq         (w_wf_enq),
        .i_enq_data    (avs_writedata),
        .i_deq         (user_write_deq),
        .o_head        (user_write_data),
        .o_empty       (user_write_empty),
        .o_almost_full (w_wf_af)
    );

    avs_data_fifo #(
        .ADDR_W (FIFO_ADDR_WIDTH),
        .DATA_W (C_AVS_DATA_WIDTH)
    ) u_read_fifo (
        .i_clk         (ACLK),
        .i_rst         (ARESET),
        .i_enq         (user_read_enq),
        .i_enq_data    (user_read_data),
        .i_deq         (w_rf_deq),
        .o_head        (w_rf_head),
        .o_empty       (w_rf_empty),
        .o_almost_full (user_read_almost_full)
    );

endmodule
